// File: rtl/boot_loader_ctrl_pkg.sv
// Shared uDLX boot/fetch definitions: boot sequencer state encodings and PC step.
package boot_loader_ctrl_pkg;

   // Byte distance between consecutive instruction words (also used by fetch).
   localparam int unsigned PC_INCREMENT = 4;

   typedef enum logic [1:0] {
      BOOT_LOAD    = 2'd0,
      BOOT_RELEASE = 2'd1,
      BOOT_RUN     = 2'd2
   } boot_state_e;

endpackage

// File: rtl/boot_loader_ctrl.sv
// Boot sequencer for the uDLX fetch stage. Holds the core in boot mode, streams the
// program image from a valid/ready loader into instruction SRAM, then releases fetch
// and hands the SRAM address port over to the fetch PC.
module boot_loader_ctrl
   import boot_loader_ctrl_pkg::*;
#(
   parameter int unsigned               PC_DATA_WIDTH      = 20,
   parameter int unsigned               INSTRUCTION_WIDTH  = 32,
   parameter logic [PC_DATA_WIDTH-1:0]  PC_INITIAL_ADDRESS = '0,
   parameter int unsigned               MAX_WORDS          = 1024,
   parameter int unsigned               RELEASE_CYCLES     = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          boot_req,
   input  logic                          load_valid,
   output logic                          load_ready,
   input  logic [INSTRUCTION_WIDTH-1:0]  load_data,
   input  logic                          load_last,
   input  logic [PC_DATA_WIDTH-1:0]      fetch_addr_in,
   output logic [PC_DATA_WIDTH-1:0]      inst_mem_addr_out,
   output logic                          inst_mem_we_out,
   output logic [INSTRUCTION_WIDTH-1:0]  inst_mem_data_out,
   output logic                          boot_mode,
   output logic                          core_en,
   output logic                          boot_overflow
);

   localparam int CNT_W = $clog2(MAX_WORDS + 1);
   localparam int REL_W = $clog2(RELEASE_CYCLES + 1);
   localparam logic [CNT_W-1:0]         WORD_LIMIT = CNT_W'(MAX_WORDS);
   localparam logic [REL_W-1:0]         REL_LAST   = REL_W'(RELEASE_CYCLES - 1);
   localparam logic [PC_DATA_WIDTH-1:0] ADDR_STEP  = PC_DATA_WIDTH'(PC_INCREMENT);

   boot_state_e                  state_q, state_d;
   logic [PC_DATA_WIDTH-1:0]     wr_addr_q, wr_addr_d;
   logic [PC_DATA_WIDTH-1:0]     pend_addr_q, pend_addr_d;   // address of the write now on the port
   logic [CNT_W-1:0]             word_cnt_q, word_cnt_d;
   logic [REL_W-1:0]             rel_cnt_q, rel_cnt_d;
   logic                         we_q, we_d;
   logic [INSTRUCTION_WIDTH-1:0] data_q, data_d;
   logic                         overflow_q, overflow_d;

   // State and datapath registers; async reset returns to a fresh LOAD at the initial PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= BOOT_LOAD;
         wr_addr_q   <= PC_INITIAL_ADDRESS;
         pend_addr_q <= PC_INITIAL_ADDRESS;
         word_cnt_q  <= '0;
         rel_cnt_q   <= '0;
         we_q        <= 1'b0;
         data_q      <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_addr_q   <= wr_addr_d;
         pend_addr_q <= pend_addr_d;
         word_cnt_q  <= word_cnt_d;
         rel_cnt_q   <= rel_cnt_d;
         we_q        <= we_d;
         data_q      <= data_d;
         overflow_q  <= overflow_d;
      end
   end

   // Next-state logic: accept words in LOAD, hold RELEASE for a fixed count, wait for boot_req in RUN.
   always_comb begin
      state_d     = state_q;
      wr_addr_d   = wr_addr_q;
      pend_addr_d = pend_addr_q;
      word_cnt_d  = word_cnt_q;
      rel_cnt_d   = rel_cnt_q;
      we_d        = 1'b0;
      data_d      = data_q;
      overflow_d  = overflow_q;
      case (state_q)
         BOOT_LOAD: begin
            if (load_valid) begin
               we_d        = 1'b1;
               data_d      = load_data;
               pend_addr_d = wr_addr_q;
               wr_addr_d   = wr_addr_q + ADDR_STEP;
               word_cnt_d  = word_cnt_q + CNT_W'(1);
               if (load_last) begin
                  state_d = BOOT_RELEASE;
               end else if (word_cnt_d == WORD_LIMIT) begin
                  // Image filled the SRAM without a last marker: truncate and flag it.
                  state_d    = BOOT_RELEASE;
                  overflow_d = 1'b1;
               end
            end
         end
         BOOT_RELEASE: begin
            if (rel_cnt_q == REL_LAST) begin
               rel_cnt_d = '0;
               state_d   = BOOT_RUN;
            end else begin
               rel_cnt_d = rel_cnt_q + REL_W'(1);
            end
         end
         BOOT_RUN: begin
            if (boot_req) begin
               state_d    = BOOT_LOAD;
               wr_addr_d  = PC_INITIAL_ADDRESS;
               word_cnt_d = '0;
               overflow_d = 1'b0;
            end
         end
         default: begin
            state_d = BOOT_LOAD;
         end
      endcase
   end

   // Port outputs decoded from state; SRAM address follows fetch only once the core runs.
   always_comb begin
      load_ready = (state_q == BOOT_LOAD);
      boot_mode  = (state_q != BOOT_RUN);
      core_en    = (state_q == BOOT_RUN);
      if (state_q == BOOT_RUN) begin
         inst_mem_addr_out = fetch_addr_in;
      end else if (we_q) begin
         inst_mem_addr_out = pend_addr_q;
      end else begin
         inst_mem_addr_out = wr_addr_q;
      end
   end

   assign inst_mem_we_out   = we_q;
   assign inst_mem_data_out = data_q;
   assign boot_overflow     = overflow_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl (MAX_WORDS=4, RELEASE_CYCLES=2).
module tb_boot_loader_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        boot_req;
   logic        load_valid;
   logic        load_ready;
   logic [31:0] load_data;
   logic        load_last;
   logic [19:0] fetch_addr_in;
   logic [19:0] inst_mem_addr_out;
   logic        inst_mem_we_out;
   logic [31:0] inst_mem_data_out;
   logic        boot_mode;
   logic        core_en;
   logic        boot_overflow;

   int checks   = 0;
   int failures = 0;

   boot_loader_ctrl #(
      .PC_DATA_WIDTH      (20),
      .INSTRUCTION_WIDTH  (32),
      .PC_INITIAL_ADDRESS (20'h0),
      .MAX_WORDS          (4),
      .RELEASE_CYCLES     (2)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .boot_req          (boot_req),
      .load_valid        (load_valid),
      .load_ready        (load_ready),
      .load_data         (load_data),
      .load_last         (load_last),
      .fetch_addr_in     (fetch_addr_in),
      .inst_mem_addr_out (inst_mem_addr_out),
      .inst_mem_we_out   (inst_mem_we_out),
      .inst_mem_data_out (inst_mem_data_out),
      .boot_mode         (boot_mode),
      .core_en           (core_en),
      .boot_overflow     (boot_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expect a write of data to addr on the SRAM port this cycle.
   task automatic chk_write(input string tag, input logic [19:0] addr, input logic [31:0] data);
      chk({tag, "_we"},   32'(inst_mem_we_out), 32'd1);
      chk({tag, "_addr"}, 32'(inst_mem_addr_out), 32'(addr));
      chk({tag, "_data"}, inst_mem_data_out, data);
      $display("write %s addr=%h data=%h", tag, inst_mem_addr_out, inst_mem_data_out);
   endtask

   // Present one word for a single cycle, then drop valid.
   task automatic send(input logic [31:0] data, input logic last);
      load_valid = 1'b1;
      load_data  = data;
      load_last  = last;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   initial begin
      rst_n         = 1'b0;
      boot_req      = 1'b0;
      load_valid    = 1'b0;
      load_data     = '0;
      load_last     = 1'b0;
      fetch_addr_in = '0;

      // ---- reset values ----
      #3;
      chk("rst_we",       32'(inst_mem_we_out), 32'd0);
      chk("rst_data",     inst_mem_data_out, 32'd0);
      chk("rst_addr",     32'(inst_mem_addr_out), 32'd0);
      chk("rst_bootmode", 32'(boot_mode), 32'd1);
      chk("rst_core_en",  32'(core_en), 32'd0);
      chk("rst_ready",    32'(load_ready), 32'd1);
      chk("rst_ovf",      32'(boot_overflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ---- three-word image, back to back ----
      load_valid = 1'b1; load_data = 32'h11; load_last = 1'b0;
      tick();
      chk_write("w0", 20'h0, 32'h11);
      load_data = 32'h22;
      tick();
      chk_write("w1", 20'h4, 32'h22);
      load_data = 32'h33; load_last = 1'b1;
      tick();                                  // cycle c+1 after the last accept
      load_valid = 1'b0; load_last = 1'b0;
      chk_write("w2", 20'h8, 32'h33);
      #1;
      chk("rel1_ready",    32'(load_ready), 32'd0);
      chk("rel1_bootmode", 32'(boot_mode), 32'd1);
      chk("rel1_core_en",  32'(core_en), 32'd0);
      tick();                                  // c+2
      chk("rel2_we",       32'(inst_mem_we_out), 32'd0);
      chk("rel2_addr",     32'(inst_mem_addr_out), 32'hC);
      chk("rel2_bootmode", 32'(boot_mode), 32'd1);
      chk("rel2_core_en",  32'(core_en), 32'd0);
      tick();                                  // c+3
      chk("run_core_en",   32'(core_en), 32'd1);
      chk("run_bootmode",  32'(boot_mode), 32'd0);
      chk("run_ovf",       32'(boot_overflow), 32'd0);
      $display("txn load3 core_en=%0d", core_en);

      // ---- RUN: fetch passthrough, stray load_valid ignored ----
      fetch_addr_in = 20'h10;
      load_valid    = 1'b1; load_data = 32'hDEAD;
      #1;
      chk("run_addr",  32'(inst_mem_addr_out), 32'h10);
      chk("run_ready", 32'(load_ready), 32'd0);
      tick();
      chk("run_we",    32'(inst_mem_we_out), 32'd0);
      chk("run_data",  inst_mem_data_out, 32'h33);
      load_valid = 1'b0;
      $display("txn run_passthrough addr=%h", inst_mem_addr_out);

      // ---- boot_req re-enters LOAD ----
      boot_req = 1'b1;
      tick();
      boot_req = 1'b0;
      #1;
      chk("breq_bootmode", 32'(boot_mode), 32'd1);
      chk("breq_core_en",  32'(core_en), 32'd0);
      chk("breq_ready",    32'(load_ready), 32'd1);
      chk("breq_addr",     32'(inst_mem_addr_out), 32'h0);
      $display("txn boot_req reentered load");

      // ---- gapped stream with boot_req pulses in LOAD and RELEASE ----
      send(32'hA0, 1'b0);
      chk_write("g0", 20'h0, 32'hA0);
      boot_req = 1'b1;                         // ignored in LOAD
      tick();
      boot_req = 1'b0;
      chk("gap0_we",   32'(inst_mem_we_out), 32'd0);
      chk("gap0_addr", 32'(inst_mem_addr_out), 32'h4);
      send(32'hA1, 1'b0);
      chk_write("g1", 20'h4, 32'hA1);
      tick();
      chk("gap1_we",   32'(inst_mem_we_out), 32'd0);
      send(32'hA2, 1'b0);
      chk_write("g2", 20'h8, 32'hA2);
      tick();
      send(32'hA3, 1'b1);                      // 4th word with last: no overflow
      chk_write("g3", 20'hC, 32'hA3);
      chk("g3_ovf", 32'(boot_overflow), 32'd0);
      boot_req = 1'b1;                         // ignored in RELEASE
      tick();
      boot_req = 1'b0;
      chk("grel_core_en", 32'(core_en), 32'd0);
      tick();
      chk("grun_core_en", 32'(core_en), 32'd1);
      $display("txn gapped load core_en=%0d", core_en);

      // ---- overflow: 5 words, no last, MAX_WORDS=4 ----
      boot_req = 1'b1;
      tick();
      boot_req = 1'b0;
      load_valid = 1'b1; load_last = 1'b0;
      load_data = 32'h100; tick(); chk_write("o0", 20'h0, 32'h100);
      load_data = 32'h101; tick(); chk_write("o1", 20'h4, 32'h101);
      load_data = 32'h102; tick(); chk_write("o2", 20'h8, 32'h102);
      load_data = 32'h103; tick(); chk_write("o3", 20'hC, 32'h103);
      load_data = 32'h104;                     // 5th word stays offered
      #1;
      chk("ovf_flag",  32'(boot_overflow), 32'd1);
      chk("ovf_ready", 32'(load_ready), 32'd0);
      tick();
      chk("ovf_no5th_we", 32'(inst_mem_we_out), 32'd0);
      chk("ovf_rel_core", 32'(core_en), 32'd0);
      tick();
      load_valid = 1'b0;
      chk("ovf_run_core", 32'(core_en), 32'd1);
      chk("ovf_sticky",   32'(boot_overflow), 32'd1);
      $display("txn overflow flag=%0d", boot_overflow);

      // ---- boot_req clears overflow; reset mid-load ----
      boot_req = 1'b1;
      tick();
      boot_req = 1'b0;
      chk("clr_ovf", 32'(boot_overflow), 32'd0);
      send(32'h200, 1'b0);
      chk_write("r0", 20'h0, 32'h200);
      send(32'h201, 1'b0);
      chk_write("r1", 20'h4, 32'h201);
      load_valid = 1'b1; load_data = 32'h202;
      #1;
      rst_n = 1'b0;
      #1;
      chk("mrst_we",       32'(inst_mem_we_out), 32'd0);
      chk("mrst_data",     inst_mem_data_out, 32'd0);
      chk("mrst_addr",     32'(inst_mem_addr_out), 32'd0);
      chk("mrst_bootmode", 32'(boot_mode), 32'd1);
      chk("mrst_ready",    32'(load_ready), 32'd1);
      load_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      send(32'h300, 1'b0);
      chk_write("rl0", 20'h0, 32'h300);
      send(32'h301, 1'b0);
      chk_write("rl1", 20'h4, 32'h301);
      send(32'h302, 1'b1);
      chk_write("rl2", 20'h8, 32'h302);
      tick();
      tick();
      chk("rl_core_en", 32'(core_en), 32'd1);
      $display("txn reload after reset core_en=%0d", core_en);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
